// File: rtl/instr_encoder_if.sv
// Record stream and instruction-memory write port of the program loader.
// The encoder connects as slave; the host/memory side connects as master.
interface instr_encoder_if #(
    parameter int unsigned T = 10
) ();
    logic         in_valid;
    logic         in_ready;
    logic [4:0]   in_mnem;
    logic [7:0]   in_operand;
    logic         in_last;
    logic         wr_en;
    logic [T-1:0] wr_addr;
    logic [8:0]   wr_data;
    logic         mem_ready;

    modport master (
        output in_valid, in_mnem, in_operand, in_last, mem_ready,
        input  in_ready, wr_en, wr_addr, wr_data
    );

    modport slave (
        input  in_valid, in_mnem, in_operand, in_last, mem_ready,
        output in_ready, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/instr_encoder.sv
// Program loader: range-checks symbolic records, packs them into 9-bit words and
// streams them through a small FIFO into instruction memory from base_addr upward.
module instr_encoder #(
    parameter int unsigned T     = 10,
    parameter int unsigned DEPTH = 4
) (
    input  logic           Clk,
    input  logic           Reset,
    input  logic           start,
    input  logic [T-1:0]   base_addr,
    instr_encoder_if.slave bus,
    output logic           busy,
    output logic           done,
    output logic           err,
    output logic [1:0]     err_code
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic [2:0] {StIdle, StLoad, StDrain, StDone, StError} state_e;

    state_e        state_q;
    logic [8:0]    mem_q [DEPTH];
    logic [PW-1:0] rd_ptr_q, wr_ptr_q;
    logic [CW-1:0] count_q;
    logic [T:0]    acc_addr_q;  // one extra bit so address 2^T is detectable
    logic [T-1:0]  wr_addr_q;
    logic          done_q, err_q;
    logic [1:0]    err_code_q;

    logic       accept, wr_hs;
    logic [8:0] enc_word;
    logic [2:0] enc_cls;
    logic [1:0] enc_code, rec_err;
    logic [7:0] o;

    assign o = bus.in_operand;

    // enc_cls: 0 any, 1 o<=15, 2 o in 8..15, 3 o<=7, 4 operand ignored, 5 bad mnemonic
    always_comb begin
        enc_word = '0;
        enc_cls  = 3'd5;
        case (bus.in_mnem)
            5'd0:  begin enc_word = {1'b1, o};                enc_cls = 3'd0; end
            5'd1:  begin enc_word = {5'b00000, o[3:0]};       enc_cls = 3'd1; end
            5'd2:  begin enc_word = {5'b00001, o[3:0]};       enc_cls = 3'd1; end
            5'd7:  begin enc_word = {5'b00100, o[3:0]};       enc_cls = 3'd1; end
            5'd8:  begin enc_word = {5'b00101, o[3:0]};       enc_cls = 3'd1; end
            5'd9:  begin enc_word = {5'b00110, o[3:0]};       enc_cls = 3'd1; end
            5'd10: begin enc_word = {5'b00111, o[3:0]};       enc_cls = 3'd1; end
            5'd13: begin enc_word = {5'b01001, o[3:0]};       enc_cls = 3'd1; end
            5'd14: begin enc_word = {5'b01010, o[3:0]};       enc_cls = 3'd1; end
            5'd3:  begin enc_word = {6'b000100, o[2:0]};      enc_cls = 3'd2; end
            5'd4:  begin enc_word = {6'b000101, o[2:0]};      enc_cls = 3'd2; end
            5'd5:  begin enc_word = {6'b000110, o[2:0]};      enc_cls = 3'd2; end
            5'd6:  begin enc_word = {6'b000111, o[2:0]};      enc_cls = 3'd3; end
            5'd11: begin enc_word = {6'b010000, o[2:0]};      enc_cls = 3'd3; end
            5'd12: begin enc_word = {6'b010001, o[2:0]};      enc_cls = 3'd3; end
            5'd16: begin enc_word = {6'b011100, o[2:0]};      enc_cls = 3'd3; end
            5'd17: begin enc_word = {6'b011101, o[2:0]};      enc_cls = 3'd3; end
            5'd18: begin enc_word = {6'b011110, o[2:0]};      enc_cls = 3'd3; end
            5'd19: begin enc_word = {6'b011111, o[2:0]};      enc_cls = 3'd3; end
            5'd15: begin enc_word = 9'b0_1011_0000;           enc_cls = 3'd4; end
            default: ;
        endcase
    end

    always_comb begin
        enc_code = 2'b00;
        case (enc_cls)
            3'd1: if (o[7:4] != 4'd0) enc_code = 2'b10;
            3'd2: if (o[7:3] != 5'b00001) enc_code = 2'b10;
            3'd3: if (o[7:3] != 5'd0) enc_code = 2'b10;
            3'd5: enc_code = 2'b01;
            default: ;
        endcase
    end

    assign rec_err = acc_addr_q[T] ? 2'b11 : enc_code;

    assign busy         = (state_q == StLoad) || (state_q == StDrain);
    assign bus.in_ready = (state_q == StLoad) && (count_q < CW'(DEPTH));
    assign bus.wr_en    = busy && (count_q != '0);
    assign bus.wr_addr  = wr_addr_q;
    assign bus.wr_data  = bus.wr_en ? mem_q[rd_ptr_q] : 9'd0;
    assign done         = done_q;
    assign err          = err_q;
    assign err_code     = err_code_q;

    assign accept = bus.in_valid && bus.in_ready;
    assign wr_hs  = bus.wr_en && bus.mem_ready;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= StIdle;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            acc_addr_q <= '0;
            wr_addr_q  <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= 2'b00;
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle, StDone, StError: begin
                    if (start) begin
                        state_q    <= StLoad;
                        err_q      <= 1'b0;
                        err_code_q <= 2'b00;
                        rd_ptr_q   <= '0;
                        wr_ptr_q   <= '0;
                        count_q    <= '0;
                        acc_addr_q <= {1'b0, base_addr};
                        wr_addr_q  <= base_addr;
                    end
                end
                StLoad, StDrain: begin
                    if (accept && rec_err != 2'b00) begin
                        // Erroring record is dropped and anything still buffered is discarded
                        state_q    <= StError;
                        err_q      <= 1'b1;
                        err_code_q <= rec_err;
                        rd_ptr_q   <= '0;
                        wr_ptr_q   <= '0;
                        count_q    <= '0;
                    end else begin
                        if (accept) begin
                            mem_q[wr_ptr_q] <= enc_word;
                            wr_ptr_q        <= wr_ptr_q + PW'(1);
                            acc_addr_q      <= acc_addr_q + (T+1)'(1);
                        end
                        if (wr_hs) begin
                            rd_ptr_q  <= rd_ptr_q + PW'(1);
                            wr_addr_q <= wr_addr_q + T'(1);
                        end
                        count_q <= count_q + CW'(accept) - CW'(wr_hs);
                        if (accept && bus.in_last) state_q <= StDrain;
                        if (state_q == StDrain && wr_hs && count_q == CW'(1)) begin
                            state_q <= StDone;
                            done_q  <= 1'b1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_instr_encoder.sv
// Randomised and directed bench for instr_encoder, checked against a table-driven
// model of the instruction encoding and of the load/error sequencing.
module tb_instr_encoder;
    localparam int unsigned T     = 10;
    localparam int unsigned DEPTH = 4;

    logic         Clk = 1'b0;
    logic         Reset = 1'b1;
    logic         start = 1'b0;
    logic [T-1:0] base_addr = '0;
    logic         busy, done, err;
    logic [1:0]   err_code;

    instr_encoder_if #(.T(T)) bus ();

    instr_encoder #(.T(T), .DEPTH(DEPTH)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .start     (start),
        .base_addr (base_addr),
        .bus       (bus),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .err_code  (err_code)
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    // Model: operand class and opcode prefix per mnemonic
    // class 0 any, 1 nibble, 2 three bits in 8..15, 3 three bits <=7, 4 fixed word, 5 invalid
    int cls_t [32];
    int op_t  [32];

    initial begin
        int n4m [8] = '{1, 2, 7, 8, 9, 10, 13, 14};
        int n4o [8] = '{0, 1, 4, 5, 6, 7, 9, 10};
        int h3m [3] = '{3, 4, 5};
        int h3o [3] = '{4, 5, 6};
        int l3m [7] = '{6, 12, 16, 17, 18, 19, 11};
        int l3o [7] = '{7, 17, 28, 29, 30, 31, 16};
        for (int i = 0; i < 32; i++) begin cls_t[i] = 5; op_t[i] = 0; end
        cls_t[0] = 0;
        cls_t[15] = 4;
        for (int i = 0; i < 8; i++) begin cls_t[n4m[i]] = 1; op_t[n4m[i]] = n4o[i]; end
        for (int i = 0; i < 3; i++) begin cls_t[h3m[i]] = 2; op_t[h3m[i]] = h3o[i]; end
        for (int i = 0; i < 7; i++) begin cls_t[l3m[i]] = 3; op_t[l3m[i]] = l3o[i]; end
    end

    function automatic void model_enc(input int m, input int o, output int word, output int code);
        word = 0;
        code = 0;
        case (cls_t[m])
            0: word = 256 + o;
            1: begin word = op_t[m] * 16 + o % 16; code = (o > 15) ? 2 : 0; end
            2: begin word = op_t[m] * 8 + o % 8; code = (o >= 8 && o <= 15) ? 0 : 2; end
            3: begin word = op_t[m] * 8 + o % 8; code = (o <= 7) ? 0 : 2; end
            4: word = 'h0B0;
            default: code = 1;
        endcase
    endfunction

    int prog_m [$];
    int prog_o [$];

    function automatic int legal_operand(input int m);
        case (cls_t[m])
            1: return $urandom_range(0, 15);
            2: return $urandom_range(8, 15);
            3: return $urandom_range(0, 7);
            default: return $urandom_range(0, 255);
        endcase
    endfunction

    // Memory-side ready: 0 always, 1 random, 2 low for stall_left cycles then high, 3 always low
    int rdy_mode   = 0;
    int stall_left = 0;
    initial bus.mem_ready = 1'b1;
    always @(posedge Clk) begin
        #1;
        case (rdy_mode)
            0: bus.mem_ready = 1'b1;
            1: bus.mem_ready = ($urandom_range(0, 2) != 0);
            2: begin
                bus.mem_ready = (stall_left == 0);
                if (stall_left > 0) stall_left--;
            end
            default: bus.mem_ready = 1'b0;
        endcase
    end

    // Monitor: samples at negedge, between drive (posedge+1) and the next active edge
    int       cyc = 0;
    int       obs_addr [$];
    int       obs_data [$];
    int       n_acc, acc_before_wr, n_done, done_cyc, first_wr_cyc, last_wr_cyc, n_unstable;
    bit       prev_stall = 1'b0;
    int       prev_addr, prev_data;

    always @(posedge Clk) cyc++;

    always @(negedge Clk) begin
        if (bus.in_valid && bus.in_ready) begin
            n_acc++;
            if (obs_addr.size() == 0) acc_before_wr++;
        end
        if (bus.wr_en && bus.mem_ready) begin
            obs_addr.push_back(int'(bus.wr_addr));
            obs_data.push_back(int'(bus.wr_data));
            if (first_wr_cyc < 0) first_wr_cyc = cyc;
            last_wr_cyc = cyc;
        end
        if (done) begin n_done++; done_cyc = cyc; end
        if (prev_stall && !Reset &&
            (!bus.wr_en || int'(bus.wr_addr) != prev_addr || int'(bus.wr_data) != prev_data))
            n_unstable++;
        prev_stall = bus.wr_en && !bus.mem_ready && !Reset;
        prev_addr  = int'(bus.wr_addr);
        prev_data  = int'(bus.wr_data);
    end

    task automatic clear_monitor();
        obs_addr.delete();
        obs_data.delete();
        n_acc = 0; acc_before_wr = 0; n_done = 0; done_cyc = -1;
        first_wr_cyc = -1; last_wr_cyc = -1; n_unstable = 0;
    endtask

    task automatic pulse_start(input int base);
        base_addr = T'(base);
        start = 1'b1;
        @(posedge Clk); #1;
        start = 1'b0;
        check("err_clear_on_start", err, 0);
        check("busy_after_start", busy, 1);
    endtask

    // Offers prog[0..n-1]; in_last set on record total-1
    task automatic send(input int n, input int total, input bit gaps);
        for (int i = 0; i < n; i++) begin
            bit acc = 1'b0;
            int t = 0;
            if (gaps && $urandom_range(0, 3) == 0) begin
                bus.in_valid = 1'b0;
                @(posedge Clk); #1;
            end
            bus.in_valid   = 1'b1;
            bus.in_mnem    = 5'(prog_m[i]);
            bus.in_operand = 8'(prog_o[i]);
            bus.in_last    = (i == total - 1);
            while (!acc && t < 100) begin
                @(negedge Clk);
                acc = bus.in_ready;
                @(posedge Clk); #1;
                t++;
            end
            if (!acc) begin
                check("accept_timeout", 0, 1);
                break;
            end
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic run_prog(input string name, input int base, input int mode, input int stall,
                            input bit gaps);
        int exp_addr [$];
        int exp_data [$];
        int exp_code = 0;
        int n_send   = prog_m.size();
        int t = 0;
        for (int i = 0; i < prog_m.size(); i++) begin
            int w, c;
            if (base + i >= (1 << T)) begin exp_code = 3; n_send = i + 1; break; end
            model_enc(prog_m[i], prog_o[i], w, c);
            if (c != 0) begin exp_code = c; n_send = i + 1; break; end
            exp_addr.push_back(base + i);
            exp_data.push_back(w);
        end
        clear_monitor();
        rdy_mode   = mode;
        stall_left = stall;
        pulse_start(base);
        send(n_send, prog_m.size(), gaps);
        while (t < 300 && n_done == 0 && !err) begin
            @(posedge Clk); #1;
            t++;
        end
        if (t >= 300) check({name, ":completion_timeout"}, 0, 1);
        repeat (3) begin @(posedge Clk); #1; end
        check({name, ":err"}, err, (exp_code != 0));
        check({name, ":err_code"}, err_code, exp_code);
        check({name, ":busy_end"}, busy, 0);
        check({name, ":write_count"}, obs_addr.size(), exp_addr.size());
        for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++) begin
            check($sformatf("%s:addr[%0d]", name, i), obs_addr[i], exp_addr[i]);
            check($sformatf("%s:data[%0d]", name, i), obs_data[i], exp_data[i]);
        end
        if (exp_code == 0) begin
            check({name, ":done_pulses"}, n_done, 1);
            check({name, ":done_latency"}, done_cyc - last_wr_cyc, 1);
        end else begin
            check({name, ":done_pulses"}, n_done, 0);
        end
        check({name, ":wr_stable"}, n_unstable, 0);
    endtask

    task automatic set_prog(input int m [], input int o []);
        prog_m.delete();
        prog_o.delete();
        foreach (m[i]) begin prog_m.push_back(m[i]); prog_o.push_back(o[i]); end
    endtask

    initial begin
        bus.in_valid   = 1'b0;
        bus.in_mnem    = '0;
        bus.in_operand = '0;
        bus.in_last    = 1'b0;
        clear_monitor();
        repeat (2) begin @(posedge Clk); #1; end
        check("reset_outputs",
              {bus.in_ready, bus.wr_en, bus.wr_addr, bus.wr_data, busy, done, err, err_code}, 0);
        Reset = 1'b0;
        @(posedge Clk); #1;

        // Reference program, full throughput
        set_prog('{7, 0, 3, 19, 15}, '{3, 'hA5, 10, 5, 0});
        run_prog("basic", 'h010, 0, 0, 1'b0);
        check("basic:word0_const", obs_data.size() > 0 ? obs_data[0] : -1, 'h043);
        check("basic:word4_const", obs_data.size() > 4 ? obs_data[4] : -1, 'h0B0);
        check("basic:consecutive", last_wr_cyc - first_wr_cyc, 4);

        // Memory stall fills the buffer, then drains in order
        set_prog('{7, 8, 9, 10, 13, 14, 0, 1}, '{1, 2, 3, 4, 5, 6, 7, 8});
        run_prog("stall", 'h100, 2, 7, 1'b0);
        check("stall:accepts_while_stalled", acc_before_wr, DEPTH);

        // Operand range error on 2nd record, then restart clears err
        set_prog('{7, 3, 7}, '{1, 3, 2});
        run_prog("ldw_range", 'h020, 0, 0, 1'b0);
        set_prog('{11}, '{7});
        run_prog("lsh7", 'h030, 0, 0, 1'b0);
        check("lsh7:word_const", obs_data.size() > 0 ? obs_data[0] : -1, 'h087);
        set_prog('{25}, '{0});
        run_prog("bad_mnem", 'h040, 0, 0, 1'b0);
        set_prog('{11}, '{8});
        run_prog("lsh8", 'h050, 0, 0, 1'b0);
        // Overflow takes priority over a bad mnemonic on the same record
        set_prog('{1, 2, 25}, '{1, 2, 0});
        run_prog("overflow", 'h3FE, 0, 0, 1'b0);

        // Random legal programs with random memory backpressure and valid gaps
        for (int p = 0; p < 8; p++) begin
            int len = $urandom_range(1, 12);
            prog_m.delete();
            prog_o.delete();
            for (int i = 0; i < len; i++) begin
                int m = $urandom_range(0, 19);
                prog_m.push_back(m);
                prog_o.push_back(legal_operand(m));
            end
            run_prog($sformatf("rand%0d", p), $urandom_range(0, 'h300), 1, 0, 1'b1);
        end

        // Random programs that may contain an error (full-rate memory so no words are flushed)
        for (int p = 0; p < 4; p++) begin
            int len = $urandom_range(2, 8);
            prog_m.delete();
            prog_o.delete();
            for (int i = 0; i < len; i++) begin
                prog_m.push_back($urandom_range(0, 23));
                prog_o.push_back($urandom_range(0, 20));
            end
            run_prog($sformatf("rerr%0d", p), $urandom_range('h3F8, 'h3FF), 0, 0, 1'b1);
        end

        // Reset while three words are buffered behind a stalled memory
        set_prog('{7, 8, 9}, '{1, 2, 3});
        clear_monitor();
        rdy_mode = 3;
        pulse_start('h200);
        send(3, 10, 1'b0);
        repeat (2) begin @(posedge Clk); #1; end
        check("pre_reset_wr_en", bus.wr_en, 1);
        Reset = 1'b1;
        @(posedge Clk); #1;
        check("midload_reset_outputs",
              {bus.in_ready, bus.wr_en, bus.wr_addr, bus.wr_data, busy, done, err, err_code}, 0);
        Reset = 1'b0;
        rdy_mode = 0;
        clear_monitor();
        bus.in_valid = 1'b1;
        repeat (10) begin @(posedge Clk); #1; end
        bus.in_valid = 1'b0;
        check("post_reset_no_writes", obs_addr.size(), 0);
        check("post_reset_no_accepts", n_acc, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
